// File: rtl/input_periph_if.sv
// LSU-facing load/store bus for the input peripheral, plus the press interrupt.
interface input_periph_if;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  modport master (output rd_en, wr_en, addr, wdata, input  rdata, rvalid, irq);
  modport slave  (input  rd_en, wr_en, addr, wdata, output rdata, rvalid, irq);
endinterface

// File: rtl/input_periph.sv
// Memory-mapped input peripheral: switch sync, button debounce, W1C press latch.
// Optional press interrupt and MASK register enabled by defining INPUT_IRQ_EN.
module input_periph_db #(
  parameter int DB_CYCLES = 50000,
  parameter int CW        = $clog2(DB_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise
);
  typedef enum logic {ST_STABLE, ST_COUNT} db_st_t;

  db_st_t        r_st, w_st_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_level, w_level_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st    <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    o_rise      = 1'b0;
    case (r_st)
      ST_STABLE: begin
        if (i_sync != r_level) begin
          w_st_nxt  = ST_COUNT;
          w_cnt_nxt = CW'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_COUNT: begin
        if (i_sync == r_level) begin
          w_st_nxt  = ST_STABLE;
          w_cnt_nxt = '0;
        end else if (r_cnt >= CW'(DB_CYCLES - 1)) begin
          // this cycle's increment would reach DB_CYCLES: accept the new level
          w_st_nxt    = ST_STABLE;
          w_cnt_nxt   = '0;
          w_level_nxt = i_sync;
          o_rise      = i_sync;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_st_nxt  = ST_STABLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign o_level = r_level;
endmodule

module input_periph #(
  parameter int DB_CYCLES      = 16'd50000,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int NUM_LANES      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_sw,
  input  logic [NUM_LANES-1:0] i_btn,
  input_periph_if.slave        bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [31:0]          r_sw_s1, r_sw_s2;
  logic [NUM_LANES-1:0] w_btn_in, r_btn_s1, r_btn_s2;
  logic [NUM_LANES-1:0] w_level, w_rise, w_clr, w_mask;
  logic [NUM_LANES-1:0] r_edge;
  logic [31:0]          w_rd_mux, r_rdata;
  logic                 r_rvalid;
  logic                 w_unused;

  assign w_btn_in = BTN_ACTIVE_LOW ? ~i_btn : i_btn;
  assign w_unused = ^{bus.wdata[31:NUM_LANES], bus.addr[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= i_sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= w_btn_in;
      r_btn_s2 <= r_btn_s1;
    end
  end

  input_periph_db #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db [NUM_LANES-1:0] (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (r_btn_s2),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_clr = (bus.wr_en && bus.addr[3:2] == 2'd2) ? bus.wdata[NUM_LANES-1:0] : '0;

  // a press landing on the same cycle as its clear survives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_edge <= '0;
    else          r_edge <= (r_edge & ~w_clr) | w_rise;
  end

`ifdef INPUT_IRQ_EN
  logic [NUM_LANES-1:0] r_mask;
  logic                 r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (bus.wr_en && bus.addr[3:2] == 2'd3) r_mask <= bus.wdata[NUM_LANES-1:0];
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign w_mask  = r_mask;
  assign bus.irq = r_irq;
`else
  assign w_mask  = '0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (bus.addr[3:2])
      2'd0:    w_rd_mux = r_sw_s2;
      2'd1:    w_rd_mux[NUM_LANES-1:0] = w_level;
      2'd2:    w_rd_mux[NUM_LANES-1:0] = r_edge;
      2'd3:    w_rd_mux[NUM_LANES-1:0] = w_mask;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.rd_en;
      if (bus.rd_en) r_rdata <= w_rd_mux;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
endmodule

// File: tb/tb_input_periph.sv
// Self-checking bench for input_periph (DB_CYCLES=4, active-low buttons).
module tb_input_periph;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  input_periph_if bus();

  input_periph #(.DB_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_sw    (sw),
    .i_btn   (btn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic we, input logic [31:0] wd,
                    output logic [31:0] d, output logic v);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.wr_en = we; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    v = bus.rvalid; d = bus.rdata;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d, e; logic v;
    rst_n = 1'b0; sw = 32'hFFFF_FFFF; btn = 4'hF;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    cyc(3);
    checks++; if (bus.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    @(negedge clk); rst_n = 1'b1;
    cyc(2);
    exp_q.push_back(32'd0); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL reset_edge: got %h/%b want %h/1", d, v, e); end
  endtask

  task automatic test_sw;
    logic [31:0] d, e; logic v;
    @(negedge clk); sw = 32'd123456;
    cyc(3);
    exp_q.push_back(32'd123456); rd(4'h0, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL sw_read: got %h/%b want %h/1", d, v, e); end
    cyc(1);
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse: got %b want 0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'd123456) begin failures++; $display("FAIL rdata_hold: got %h want %h", bus.rdata, 32'd123456); end
  endtask

  task automatic test_debounce;
    logic [31:0] d, e; logic v;
    @(negedge clk); btn[0] = 1'b0;
    cyc(8);
    exp_q.push_back(32'h1); rd(4'h4, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL db_level: got %h/%b want %h/1", d, v, e); end
    exp_q.push_back(32'h1); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL db_edge: got %h/%b want %h/1", d, v, e); end
    @(negedge clk); btn[1] = 1'b0;
    cyc(2);
    @(negedge clk); btn[1] = 1'b1;
    cyc(8);
    exp_q.push_back(32'h1); rd(4'h4, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL glitch_level: got %h/%b want %h/1", d, v, e); end
    exp_q.push_back(32'h1); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL glitch_edge: got %h/%b want %h/1", d, v, e); end
  endtask

  task automatic test_w1c;
    logic [31:0] d, e; logic v;
    @(negedge clk); btn[1] = 1'b0;
    cyc(8);
    exp_q.push_back(32'h3); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL edge_two: got %h/%b want %h/1", d, v, e); end
    wr(4'h8, 32'h1);
    exp_q.push_back(32'h2); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL w1c_clear: got %h/%b want %h/1", d, v, e); end
    @(negedge clk); btn[0] = 1'b1;
    cyc(8);
    exp_q.push_back(32'h2); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL release_no_edge: got %h/%b want %h/1", d, v, e); end
    exp_q.push_back(32'h2); rd(4'h4, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL release_level: got %h/%b want %h/1", d, v, e); end
    // press accepted on the 6th rising edge after the change; clear lands on that same edge
    @(negedge clk); btn[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); bus.wr_en = 1'b1; bus.addr = 4'h8; bus.wdata = 32'h1;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    exp_q.push_back(32'h3); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL set_wins: got %h/%b want %h/1", d, v, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, e; logic v;
    exp_q.push_back(32'h3); rd(4'h8, 1'b1, 32'hF, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL rdwr_old: got %h/%b want %h/1", d, v, e); end
    exp_q.push_back(32'h0); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL rdwr_cleared: got %h/%b want %h/1", d, v, e); end
  endtask

  task automatic test_irq;
    logic [31:0] d, e; logic v;
`ifdef INPUT_IRQ_EN
    wr(4'hC, 32'h4);
    exp_q.push_back(32'h4); rd(4'hC, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL mask_read: got %h/%b want %h/1", d, v, e); end
    @(negedge clk); btn[3] = 1'b0;
    cyc(8);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b want 0", bus.irq); end
    exp_q.push_back(32'h8); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL edge_masked: got %h/%b want %h/1", d, v, e); end
    @(negedge clk); btn[2] = 1'b0;
    cyc(6);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b want 0", bus.irq); end
    cyc(1);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_assert: got %b want 1", bus.irq); end
    wr(4'h8, 32'h4);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b want 1", bus.irq); end
    cyc(1);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", bus.irq); end
`else
    wr(4'hC, 32'hF);
    exp_q.push_back(32'h0); rd(4'hC, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL mask_absent: got %h/%b want %h/1", d, v, e); end
    @(negedge clk); btn[2] = 1'b0;
    cyc(8);
    exp_q.push_back(32'h4); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL edge_btn2: got %h/%b want %h/1", d, v, e); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_tied: got %b want 0", bus.irq); end
`endif
  endtask

  task automatic test_midreset;
    logic [31:0] d, e; logic v;
    @(negedge clk); btn = 4'hF;
    cyc(8);
    @(negedge clk); btn[2] = 1'b0;
    cyc(3);
    @(negedge clk); rst_n = 1'b0;
    cyc(2);
    btn = 4'hF;
    cyc(1);
    @(negedge clk); rst_n = 1'b1;
    cyc(10);
    exp_q.push_back(32'h0); rd(4'h8, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL midreset_edge: got %h/%b want %h/1", d, v, e); end
    exp_q.push_back(32'h0); rd(4'h4, 1'b0, 0, d, v); e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || d !== e) begin failures++; $display("FAIL midreset_level: got %h/%b want %h/1", d, v, e); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL midreset_irq: got %b want 0", bus.irq); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_debounce();
    test_w1c();
    test_back_to_back();
    test_irq();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
